// File: rtl/sram_access_ctrl_pkg.sv
// rtl/sram_access_ctrl_pkg.sv - shared constants and helpers for the SRAM access controller
package sram_access_ctrl_pkg;

  // Depth of the read response buffer; the read credit limit equals this depth.
  localparam int RSP_DP = 2;

  function automatic int strb_width(input int dw);
    return (dw + 7) / 8;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - 2-entry in-order read response buffer with head-data output
module sram_rsp_fifo
  import sram_access_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [1:0]    occ,
  output logic [DW-1:0] head_data
);

  logic [DW-1:0] mem [RSP_DP];
  logic          wr_ptr;
  logic          rd_ptr;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: ;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTn)
    !(push && !pop && occ == 2'(RSP_DP)));

  a_no_underflow: assert property (@(posedge CLK) disable iff (!RSTn)
    !(pop && occ == 2'd0));

endmodule

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - valid/ready front-end for a 1W/1R byte-strobed SRAM with registered read
// Optional same-address write-to-read forwarding is enabled by defining SRAM_FWD_EN.
module sram_access_ctrl
  import sram_access_ctrl_pkg::*;
#(
  parameter  int DW = 32,
  parameter  int AW = 14,
  localparam int SW = strb_width(DW)
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [SW-1:0] wr_strb,
  output logic          wr_ack,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_rsp_valid,
  input  logic          rd_rsp_ready,
  output logic [DW-1:0] rd_rsp_data,
  output logic          sram_en_w,
  output logic [AW-1:0] sram_addr_w,
  output logic [DW-1:0] sram_data_w,
  output logic [SW-1:0] sram_wstrb,
  output logic          sram_en_r,
  output logic [AW-1:0] sram_addr_r,
  input  logic [DW-1:0] sram_data_r
);

  logic          inflight;
  logic [1:0]    occ;
  logic [DW-1:0] head_data;
  logic [DW-1:0] beat;
  logic          rd_acc;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign wr_ready    = 1'b1;
  assign sram_en_w   = wr_valid;
  assign sram_addr_w = wr_addr;
  assign sram_data_w = wr_data;
  assign sram_wstrb  = wr_strb;

  // Credit counts both buffered beats and the beat still in the SRAM pipe.
  assign rd_ready    = ({1'b0, occ} + {2'b00, inflight}) < 3'(RSP_DP);
  assign rd_acc      = rd_valid & rd_ready;
  assign sram_en_r   = rd_acc;
  assign sram_addr_r = rd_addr;

  assign fifo_empty   = (occ == 2'd0);
  assign rd_rsp_valid = !fifo_empty | inflight;
  assign rd_rsp_data  = fifo_empty ? beat : head_data;
  assign pop          = !fifo_empty & rd_rsp_ready;
  // The arriving beat bypasses the buffer only when nothing is queued ahead of it and it is taken now.
  assign push         = inflight & !(fifo_empty & rd_rsp_ready);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      inflight <= 1'b0;
      wr_ack   <= 1'b0;
    end else begin
      inflight <= rd_acc;
      wr_ack   <= wr_valid & wr_ready;
    end
  end

`ifdef SRAM_FWD_EN
  logic          fwd_hit;
  logic [SW-1:0] fwd_strb;
  logic [DW-1:0] fwd_data;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fwd_hit  <= 1'b0;
      fwd_strb <= '0;
      fwd_data <= '0;
    end else begin
      fwd_hit  <= rd_acc & wr_valid & (rd_addr == wr_addr);
      fwd_strb <= wr_strb;
      fwd_data <= wr_data;
    end
  end

  // The SRAM returns pre-write data on a collision; overlay the strobed bytes.
  always_comb begin
    beat = sram_data_r;
    if (fwd_hit) begin
      for (int i = 0; i < DW; i++) begin
        if (fwd_strb[i/8]) beat[i] = fwd_data[i];
      end
    end
  end
`else
  assign beat = sram_data_r;
`endif

  sram_rsp_fifo #(
    .DW(DW)
  ) u_rsp_fifo (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .push      (push),
    .push_data (beat),
    .pop       (pop),
    .occ       (occ),
    .head_data (head_data)
  );

endmodule
